// File: rtl/ssd_pkg.sv
// Shared constants and scan-state type for the 7-segment scan controller.
package ssd_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] NIB_BLANK = 4'hF;

  typedef enum logic {
    GAP  = 1'b0,
    SHOW = 1'b1
  } scan_state_t;
endpackage

// File: rtl/ssd_scan_ctrl_if.sv
// Datapath-side load/value bus plus board-side digit drive for ssd_scan_ctrl.
interface ssd_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   value;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic                      lz_suppress;
  logic [NUM_DIGITS-1:0]     an;
  logic [6:0]                seg;
  logic                      dp;
  logic                      frame_done;

  modport master (
    output load, value, dp_in, lz_suppress,
    input  an, seg, dp, frame_done
  );

  modport slave (
    input  load, value, dp_in, lz_suppress,
    output an, seg, dp, frame_done
  );
endinterface

// File: rtl/ssd_scan_ctrl_ssdecoder.sv
// BCD nibble to active-low {g..a} segment pattern; non-BCD codes go dark.
module ssdecoder
  import ssd_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_BLANK;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed 7-segment scanner: frame-synchronous commit of loaded data,
// per-slot blanking gap, leading-zero suppression, registered pin drive.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic          clk,
  input  logic          rst_n,
  ssd_scan_ctrl_if.slave bus
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST     = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] CNT_GAP_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST     = IW'(NUM_DIGITS - 1);

  scan_state_t               state_reg, state_next;
  logic [CW-1:0]             cnt_reg, cnt_next;
  logic [IW-1:0]             idx_reg, idx_next;
  logic [4*NUM_DIGITS-1:0]   disp_value_reg, disp_value_next;
  logic [NUM_DIGITS-1:0]     disp_dp_reg, disp_dp_next;
  logic [4*NUM_DIGITS-1:0]   shadow_value_reg, shadow_value_next;
  logic [NUM_DIGITS-1:0]     shadow_dp_reg, shadow_dp_next;
  logic                      pending_reg, pending_next;
  logic [NUM_DIGITS-1:0]     an_reg, an_next;
  logic [6:0]                seg_reg, seg_next;
  logic                      dp_reg, dp_next;
  logic                      frame_done_reg, frame_done_next;

  logic [NUM_DIGITS-1:0]     sel_onehot;
  logic [NUM_DIGITS-1:0]     zero_upper;
  logic [NUM_DIGITS-1:0]     blank_mask;
  logic [3:0]                nib_arr [NUM_DIGITS];
  logic [3:0]                nib;
  logic [6:0]                dec_seg;
  logic                      slot_end;

  // zero_upper[i]: every digit from i up to the most significant is zero
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign sel_onehot[gi] = (idx_reg == IW'(gi));
      assign zero_upper[gi] = (disp_value_reg[4*NUM_DIGITS-1:4*gi] == '0);
      if (gi == 0) begin : g_lsd
        assign blank_mask[gi] = 1'b0;
      end else begin : g_upper
        assign blank_mask[gi] = bus.lz_suppress && zero_upper[gi];
      end
      assign nib_arr[gi] = blank_mask[gi] ? NIB_BLANK : disp_value_reg[4*gi +: 4];
    end
  endgenerate

  assign nib = nib_arr[idx_reg];

  ssdecoder u_dec (
    .nib (nib),
    .seg (dec_seg)
  );

  always_comb begin
    state_next        = state_reg;
    cnt_next          = cnt_reg + 1'b1;
    idx_next          = idx_reg;
    disp_value_next   = disp_value_reg;
    disp_dp_next      = disp_dp_reg;
    shadow_value_next = shadow_value_reg;
    shadow_dp_next    = shadow_dp_reg;
    pending_next      = pending_reg;
    an_next           = '1;
    seg_next          = SEG_BLANK;
    dp_next           = 1'b1;
    slot_end          = (cnt_reg == CNT_LAST);
    frame_done_next   = slot_end && (idx_reg == IDX_LAST);

    if (slot_end) begin
      cnt_next   = '0;
      state_next = GAP;
      idx_next   = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
    end else if (cnt_reg == CNT_GAP_LAST) begin
      state_next = SHOW;
    end

    if (state_reg == SHOW) begin
      an_next  = ~sel_onehot;
      seg_next = dec_seg;
      dp_next  = ~disp_dp_reg[idx_reg];
    end

    // A load landing on the frame boundary bypasses the shadow entirely
    if (frame_done_next) begin
      if (bus.load) begin
        disp_value_next = bus.value;
        disp_dp_next    = bus.dp_in;
        pending_next    = 1'b0;
      end else if (pending_reg) begin
        disp_value_next = shadow_value_reg;
        disp_dp_next    = shadow_dp_reg;
        pending_next    = 1'b0;
      end
    end else if (bus.load) begin
      shadow_value_next = bus.value;
      shadow_dp_next    = bus.dp_in;
      pending_next      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg        <= GAP;
      cnt_reg          <= '0;
      idx_reg          <= '0;
      disp_value_reg   <= '0;
      disp_dp_reg      <= '0;
      shadow_value_reg <= '0;
      shadow_dp_reg    <= '0;
      pending_reg      <= 1'b0;
      an_reg           <= '1;
      seg_reg          <= SEG_BLANK;
      dp_reg           <= 1'b1;
      frame_done_reg   <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      idx_reg          <= idx_next;
      disp_value_reg   <= disp_value_next;
      disp_dp_reg      <= disp_dp_next;
      shadow_value_reg <= shadow_value_next;
      shadow_dp_reg    <= shadow_dp_next;
      pending_reg      <= pending_next;
      an_reg           <= an_next;
      seg_reg          <= seg_next;
      dp_reg           <= dp_next;
      frame_done_reg   <= frame_done_next;
    end
  end

  assign bus.an         = an_reg;
  assign bus.seg        = seg_reg;
  assign bus.dp         = dp_reg;
  assign bus.frame_done = frame_done_reg;
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Randomized plus directed bench for ssd_scan_ctrl against a frame-position
// reference model (4 digits, 8-cycle slots, 2-cycle blanking gap).
module tb_ssd_scan_ctrl;
  localparam int ND = 4;
  localparam int RD = 8;
  localparam int BL = 2;
  localparam int FRAME = ND * RD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ssd_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  ssd_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: position within the frame plus committed/pending data
  int          t;
  logic [15:0] m_disp, m_shadow;
  logic [3:0]  m_disp_dp, m_shadow_dp;
  bit          m_pend;

  logic [15:0] cur_v  = 16'h0;
  logic [3:0]  cur_dp = 4'h0;
  logic        cur_lz = 1'b0;

  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp, exp_fd;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0d, %0t)", tag, obs, exp, t, $time);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;
      4'h1: return 7'h79;
      4'h2: return 7'h24;
      4'h3: return 7'h30;
      4'h4: return 7'h19;
      4'h5: return 7'h12;
      4'h6: return 7'h02;
      4'h7: return 7'h78;
      4'h8: return 7'h00;
      4'h9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // One clock: drive inputs, predict the registered outputs, check after the edge
  task automatic cycle(input logic rv, input logic ld, input logic [15:0] v,
                       input logic [3:0] dpv, input logic lz);
    int d, c;
    logic [15:0] upper;
    logic [3:0] n;
    @(negedge clk);
    rst_n           = rv;
    bus.load        = ld;
    bus.value       = v;
    bus.dp_in       = dpv;
    bus.lz_suppress = lz;
    if (ld && rv) $display("[TB] load value=%h dp=%b at frame pos %0d", v, dpv, t);
    if (!rv) begin
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fd = 1'b0;
      t = 0; m_disp = '0; m_shadow = '0; m_disp_dp = '0; m_shadow_dp = '0; m_pend = 0;
    end else begin
      d = t / RD;
      c = t % RD;
      exp_fd = (t == FRAME - 1);
      if (c >= BL) begin
        exp_an = 4'hF ^ (4'b0001 << d);
        upper  = m_disp >> (4 * d);
        n      = upper[3:0];
        if (lz && d > 0 && upper == 16'h0) n = 4'hF;
        exp_seg = seg_of(n);
        exp_dp  = ~m_disp_dp[d];
      end else begin
        exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
      end
      if (t == FRAME - 1) begin
        if (ld) begin
          m_disp = v; m_disp_dp = dpv;
        end else if (m_pend) begin
          m_disp = m_shadow; m_disp_dp = m_shadow_dp;
        end
        m_pend = 0;
      end else if (ld) begin
        m_shadow = v; m_shadow_dp = dpv; m_pend = 1;
      end
      t = (t + 1) % FRAME;
    end
    @(posedge clk);
    #1;
    check_eq("an",         {12'h0, bus.an},          {12'h0, exp_an});
    check_eq("seg",        {9'h0, bus.seg},          {9'h0, exp_seg});
    check_eq("dp",         {15'h0, bus.dp},          {15'h0, exp_dp});
    check_eq("frame_done", {15'h0, bus.frame_done},  {15'h0, exp_fd});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, cur_v, cur_dp, cur_lz);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] dpv);
    cur_v  = v;
    cur_dp = dpv;
    cycle(1'b1, 1'b1, v, dpv, cur_lz);
  endtask

  task automatic wait_pos(input int pos);
    for (int i = 0; i < FRAME && t != pos; i++) idle(1);
  endtask

  function automatic logic [15:0] rand_value();
    logic [15:0] r;
    int k;
    if ($urandom_range(0, 3) == 0) return 16'($urandom());
    r = '0;
    k = $urandom_range(0, 4);
    for (int i = 0; i < 4; i++)
      if (i < k) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  initial begin
    bus.load = 1'b0; bus.value = '0; bus.dp_in = '0; bus.lz_suppress = 1'b0;
    t = 0; m_disp = '0; m_shadow = '0; m_disp_dp = '0; m_shadow_dp = '0; m_pend = 0;

    repeat (3) cycle(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);

    idle(5);
    do_load(16'h1234, 4'h0);
    idle(60);

    wait_pos(10);
    do_load(16'h5678, 4'h0);
    idle(50);
    wait_pos(3);
    do_load(16'h1111, 4'h0);
    idle(6);
    do_load(16'h2222, 4'h0);
    idle(50);

    wait_pos(FRAME - 1);
    do_load(16'h9999, 4'h0);
    idle(40);

    cur_lz = 1'b1;
    do_load(16'h0070, 4'h0);
    idle(70);
    do_load(16'h0000, 4'h0);
    idle(70);
    cur_lz = 1'b0;
    idle(40);

    do_load(16'hA0F0, 4'b0010);
    idle(70);
    wait_pos(3 * RD + 4);
    cycle(1'b0, 1'b0, cur_v, cur_dp, cur_lz);
    cur_v = 16'h0; cur_dp = 4'h0;
    idle(40);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) cur_lz = ~cur_lz;
      if ($urandom_range(0, 699) == 0) begin
        cycle(1'b0, 1'b0, cur_v, cur_dp, cur_lz);
      end else if ($urandom_range(0, 24) == 0) begin
        do_load(rand_value(), 4'($urandom_range(0, 15)));
      end else begin
        idle(1);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
